// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
//   Definitions shared by the register-file writeback controller and its
//   scoreboard.
//   Contents:
//     XLEN, NUM_REGS, REG_IDX_W : datapath and register-file geometry
//     wb_req_t                  : one writeback request {valid, rd, data}
//     wb_grant_e                : which requester owns the write port
//     reg_mask()                : one-hot mask for a register index
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LSU  = 2'd2
    } wb_grant_e;

    // One-hot mask selecting register idx. The caller masks out x0.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// ----------------------------------------------------------------------------
// rf_scoreboard
//   Tracks which architectural registers have a write in flight and blocks
//   issue of any instruction that reads or overwrites one of them.
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     iss_valid             : decode presents an instruction
//     iss_rd/iss_rs1/iss_rs2: destination and source register indices
//     clr_en, clr_rd        : a write to clr_rd is being committed this cycle
//     stall                 : issue blocked (combinational)
//     busy                  : bit n set means register n has a pending write
// ----------------------------------------------------------------------------
module rf_scoreboard
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iss_valid,
    input  logic [REG_IDX_W-1:0] iss_rd,
    input  logic [REG_IDX_W-1:0] iss_rs1,
    input  logic [REG_IDX_W-1:0] iss_rs2,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_rd,
    output logic                 stall,
    output logic [NUM_REGS-1:0]  busy
);

    logic [NUM_REGS-1:0] busy_p0;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic                issue_fire;

    // Hazard check uses the busy state as it stands this cycle. A commit that
    // clears a bit at the coming edge is deliberately not bypassed, so the
    // dependent instruction issues one cycle after the write is visible.
    // x0 is never busy, so index 0 cannot cause a stall.
    always_comb begin
        stall = iss_valid &&
                (busy_p0[iss_rs1] || busy_p0[iss_rs2] || busy_p0[iss_rd]);
    end

    always_comb begin
        issue_fire = iss_valid && !stall && (iss_rd != '0);
    end

    // Clear first, then set: an issue that targets the register being
    // committed in the same cycle leaves it busy for the new producer.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_fire) begin
            set_mask = reg_mask(iss_rd);
        end
        if (clr_en) begin
            clr_mask = reg_mask(clr_rd);
        end
        busy_next    = (busy_p0 & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    // ---- stage p0: scoreboard state ----
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_p0 <= '0;
        end else begin
            busy_p0 <= busy_next;
        end
    end

    assign busy = busy_p0;

endmodule

// File: rtl/rf_wb_ctrl.sv
// ----------------------------------------------------------------------------
// rf_wb_ctrl
//   Arbitrates the single register-file write port between the ALU and the
//   load unit, registers the winning write, and hosts the issue scoreboard.
//   The load unit normally wins; a starve counter guarantees the ALU a grant
//   after STARVE_LIMIT consecutive lost cycles.
//   Parameters:
//     STARVE_LIMIT : max consecutive cycles a valid ALU request may lose (>=1)
//   Ports:
//     clk, rst                               : clock, sync active-high reset
//     iss_valid_i, iss_rd_i, iss_rs1_i/rs2_i : instruction offered for issue
//     stall_o                                : issue blocked (combinational)
//     alu_valid_i/rd_i/data_i, alu_ready_o   : ALU writeback handshake
//     lsu_valid_i/rd_i/data_i, lsu_ready_o   : load-unit writeback handshake
//     rf_we_o, rf_sel_rd_o, rf_rd_o          : registered register-file write
//     busy_o                                 : pending-write scoreboard
// ----------------------------------------------------------------------------
module rf_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iss_valid_i,
    input  logic [REG_IDX_W-1:0] iss_rd_i,
    input  logic [REG_IDX_W-1:0] iss_rs1_i,
    input  logic [REG_IDX_W-1:0] iss_rs2_i,
    output logic                 stall_o,
    input  logic                 alu_valid_i,
    input  logic [REG_IDX_W-1:0] alu_rd_i,
    input  logic [XLEN-1:0]      alu_data_i,
    output logic                 alu_ready_o,
    input  logic                 lsu_valid_i,
    input  logic [REG_IDX_W-1:0] lsu_rd_i,
    input  logic [XLEN-1:0]      lsu_data_i,
    output logic                 lsu_ready_o,
    output logic                 rf_we_o,
    output logic [REG_IDX_W-1:0] rf_sel_rd_o,
    output logic [XLEN-1:0]      rf_rd_o,
    output logic [NUM_REGS-1:0]  busy_o
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    // Saturating increment of the starve counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= CNT_MAX) begin
            return CNT_MAX;
        end
        return v + CNT_W'(1);
    endfunction

    wb_req_t          alu_req;
    wb_req_t          lsu_req;
    wb_req_t          win_req;
    wb_grant_e        gnt;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;
    logic             hs_commit;
    wb_req_t          wb_p1;

    always_comb begin
        alu_req.valid = alu_valid_i;
        alu_req.rd    = alu_rd_i;
        alu_req.data  = alu_data_i;
        lsu_req.valid = lsu_valid_i;
        lsu_req.rd    = lsu_rd_i;
        lsu_req.data  = lsu_data_i;
    end

    always_comb begin
        starve_hit = (starve_cnt == CNT_MAX);
    end

    // Load unit has priority except when the ALU has been starved for the
    // full limit. If the ALU has dropped its request the limit is moot and
    // the load unit keeps the port. Nothing is granted during reset.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            if (lsu_req.valid && !(alu_req.valid && starve_hit)) begin
                gnt = GNT_LSU;
            end else if (alu_req.valid) begin
                gnt = GNT_ALU;
            end
        end
    end

    always_comb begin
        alu_ready_o = (gnt == GNT_ALU);
        lsu_ready_o = (gnt == GNT_LSU);
    end

    always_comb begin
        win_req = '0;
        case (gnt)
            GNT_ALU: win_req = alu_req;
            GNT_LSU: win_req = lsu_req;
            default: win_req = '0;
        endcase
    end

    // A write to x0 is accepted but never reaches the register file.
    always_comb begin
        hs_commit = win_req.valid && (win_req.rd != '0);
    end

    // ---- stage p1: registered write port and starve counter ----
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_p1      <= '0;
            starve_cnt <= '0;
        end else begin
            wb_p1.valid <= hs_commit;
            if (hs_commit) begin
                wb_p1.rd   <= win_req.rd;
                wb_p1.data <= win_req.data;
            end
            if (!alu_req.valid || (gnt == GNT_ALU)) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= sat_inc(starve_cnt);
            end
        end
    end

    always_comb begin
        rf_we_o     = wb_p1.valid;
        rf_sel_rd_o = wb_p1.rd;
        rf_rd_o     = wb_p1.data;
    end

    // The committing write frees its destination in the scoreboard.
    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid_i),
        .iss_rd    (iss_rd_i),
        .iss_rs1   (iss_rs1_i),
        .iss_rs2   (iss_rs2_i),
        .clr_en    (wb_p1.valid),
        .clr_rd    (wb_p1.rd),
        .stall     (stall_o),
        .busy      (busy_o)
    );

endmodule
